// File: rtl/constraint_sample_driver_if.sv
// rtl/constraint_sample_driver_if.sv - checker-side bundle of the constraint sample driver
//
// Purpose: groups the search-control, candidate and status signals that pass between
// the sample driver and its user and checker.
// Ports (signals):
//   seed_we, seed_in  seed load request and 64-bit seed value
//   start, abort      begin and cancel a search
//   cand, cand_valid  registered candidate and its evaluation strobe
//   sat_in            combinational checker verdict for cand
//   busy, done        search in progress / one-cycle end-of-search pulse
//   found, result     outcome of the last search
//   tries             candidates evaluated in the last/current search
// Modports: master = driver side, slave = user/checker side.
interface constraint_sample_driver_if #(
  parameter int WIDTH     = 55,
  parameter int MAX_TRIES = 1024,
  parameter int TRY_W     = $clog2(MAX_TRIES + 1)
) ();
  logic             seed_we;
  logic [63:0]      seed_in;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] cand;
  logic             cand_valid;
  logic             sat_in;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [TRY_W-1:0] tries;

  modport master (
    input  seed_we, seed_in, start, abort, sat_in,
    output cand, cand_valid, busy, done, found, result, tries
  );

  modport slave (
    output seed_we, seed_in, start, abort, sat_in,
    input  cand, cand_valid, busy, done, found, result, tries
  );
endinterface

// File: rtl/constraint_sample_driver.sv
// rtl/constraint_sample_driver.sv - xorshift64 random-sampling driver for a constraint checker
//
// Purpose: on start, feeds one xorshift64 candidate per cycle to a combinational
// checker, samples its verdict and stops on the first satisfying candidate, on
// exhaustion of the try budget, or on abort.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    constraint_sample_driver_if.master (seed/start/abort in, cand/status out,
//          sat_in verdict in)
module constraint_sample_driver #(
  parameter int          WIDTH     = 55,
  parameter int          MAX_TRIES = 1024,
  parameter int          TRY_W     = $clog2(MAX_TRIES + 1),
  parameter logic [63:0] ZERO_SEED = 64'h9E3779B97F4A7C15
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  constraint_sample_driver_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [63:0]      r_gen;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_result;
  logic [TRY_W-1:0] r_tries;
  logic             r_found;

  logic             w_busy;
  logic             w_done;
  logic [63:0]      w_seed_val;
  logic [63:0]      w_gen_base;
  logic [63:0]      w_gen_start;
  logic [63:0]      w_gen_step;
  logic [TRY_W-1:0] w_tries_inc;
  logic             w_last;

  function automatic logic [63:0] f_xorshift(input logic [63:0] s);
    logic [63:0] v;
    v = s;
    v = v ^ (v << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  // A zero state would lock xorshift at zero forever, so it is never loaded.
  assign w_seed_val  = (bus.seed_in == 64'd0) ? ZERO_SEED : bus.seed_in;
  // A seed loaded in the start cycle is the base of that search's first step.
  assign w_gen_base  = bus.seed_we ? w_seed_val : r_gen;
  assign w_gen_start = f_xorshift(w_gen_base);
  assign w_gen_step  = f_xorshift(r_gen);
  assign w_tries_inc = r_tries + 1'b1;
  assign w_last      = (w_tries_inc == TRY_W'(MAX_TRIES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = ST_EVAL;
        end
      end
      ST_EVAL: begin
        w_busy = 1'b1;
        if (bus.abort) begin
          w_next_state = ST_IDLE;
        end else if (bus.sat_in || w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gen    <= ZERO_SEED;
      r_cand   <= '0;
      r_result <= '0;
      r_tries  <= '0;
      r_found  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_gen    <= w_gen_start;
            r_cand   <= w_gen_start[WIDTH-1:0];
            r_tries  <= '0;
            r_found  <= 1'b0;
            r_result <= '0;
          end else if (bus.seed_we) begin
            r_gen <= w_seed_val;
          end
        end
        ST_EVAL: begin
          // An aborted cycle is not counted and does not advance the generator.
          if (!bus.abort) begin
            r_tries <= w_tries_inc;
            if (bus.sat_in) begin
              r_result <= r_cand;
              r_found  <= 1'b1;
            end else if (!w_last) begin
              r_gen  <= w_gen_step;
              r_cand <= w_gen_step[WIDTH-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cand       = r_cand;
  assign bus.cand_valid = w_busy;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.found      = r_found;
  assign bus.result     = r_result;
  assign bus.tries      = r_tries;

endmodule

// File: tb/tb_constraint_sample_driver.sv
// tb/tb_constraint_sample_driver.sv - self-checking bench for constraint_sample_driver
module tb_constraint_sample_driver;

  localparam int          W     = 55;
  localparam int          MAXT  = 1024;
  localparam int          TW    = $clog2(MAXT + 1);
  localparam int          TW8   = $clog2(8 + 1);
  localparam logic [63:0] ZSEED = 64'h9E3779B97F4A7C15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   mode;
  logic [63:0] m_s;

  constraint_sample_driver_if #(.WIDTH(W), .MAX_TRIES(MAXT), .TRY_W(TW)) bus ();
  constraint_sample_driver_if #(.WIDTH(W), .MAX_TRIES(8), .TRY_W(TW8)) bus8 ();

  constraint_sample_driver #(.WIDTH(W), .MAX_TRIES(MAXT), .TRY_W(TW)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  constraint_sample_driver #(.WIDTH(W), .MAX_TRIES(8), .TRY_W(TW8)) u_dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] xs(input logic [63:0] s);
    logic [63:0] v;
    v = s;
    v = v ^ (v << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  // Checker models: 0 always-true reduction, 1 never, 2 low nibble == A, 3 low 6 bits == 6'h2B
  function automatic logic pred(input int m, input logic [W-1:0] c);
    logic [W-1:0] k;
    k = 55'h79e95d6d76cb31;
    case (m)
      0: return |(c | k);
      2: return c[3:0] == 4'hA;
      3: return c[5:0] == 6'h2B;
      default: return 1'b0;
    endcase
  endfunction

  assign bus.sat_in  = pred(mode, bus.cand);
  assign bus8.sat_in = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic do_search(input logic [63:0] seed, input bit load, input int m, input bit junk);
    int           n;
    bit           f;
    logic [W-1:0] c;
    @(posedge clk); #1;
    mode = m;
    if (load) begin
      bus.seed_we = 1'b1;
      bus.seed_in = seed;
      m_s = (seed == 64'd0) ? ZSEED : seed;
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.seed_we = 1'b0;
    n = 0;
    f = 1'b0;
    c = '0;
    while (!f && n < MAXT) begin
      m_s = xs(m_s);
      c   = m_s[W-1:0];
      n++;
      chk("cand", bus.cand, c);
      chk("cand_valid", bus.cand_valid, 1);
      if (junk && n == 1) begin
        bus.seed_we = 1'b1;
        bus.seed_in = {$urandom, $urandom};
        bus.start   = 1'b1;
      end
      f = pred(m, c);
      @(posedge clk); #1;
      if (junk && n == 1) begin
        bus.seed_we = 1'b0;
        bus.start   = 1'b0;
      end
    end
    chk("done", bus.done, 1);
    chk("busy_done", bus.busy, 0);
    chk("found", bus.found, f);
    chk("tries", bus.tries, n);
    chk("result", bus.result, f ? c : '0);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] c8;
    logic [63:0]  s8;
    int           cnt;
    int           dcnt;
    checks = 0;
    errors = 0;
    mode   = 0;
    m_s    = ZSEED;
    bus.seed_we  = 1'b0; bus.seed_in  = '0; bus.start  = 1'b0; bus.abort  = 1'b0;
    bus8.seed_we = 1'b0; bus8.seed_in = '0; bus8.start = 1'b0; bus8.abort = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_cand", bus.cand, 0);
    chk("rst_tries", bus.tries, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_found", bus.found, 0);

    // Scenario 1: seed 1, always-true checker
    do_search(64'd1, 1'b1, 0, 1'b0);
    chk("s1_result_const", bus.result, 55'h40822041);
    chk("s1_tries_const", bus.tries, 1);

    // Scenario 3: nibble checker from seed 1, then random seeds
    do_search(64'd1, 1'b1, 2, 1'b0);
    for (int i = 0; i < 4; i++) do_search({$urandom, $urandom}, 1'b1, 2 + (i % 2), 1'b0);

    // Exhaustion at the full budget
    do_search(64'd0, 1'b0, 1, 1'b0);

    // Scenario 2: MAX_TRIES=8 instance, checker tied low, generator from ZERO_SEED
    s8 = ZSEED; cnt = 0; dcnt = 0;
    @(posedge clk); #1; bus8.start = 1'b1;
    @(posedge clk); #1; bus8.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.cand_valid) begin
        s8 = xs(s8);
        c8 = s8[W-1:0];
        chk("s2_cand", bus8.cand, c8);
        cnt++;
      end
      if (bus8.done) dcnt++;
      @(posedge clk); #1;
    end
    chk("s2_valid_cycles", cnt, 8);
    chk("s2_done_pulses", dcnt, 1);
    chk("s2_found", bus8.found, 0);
    chk("s2_tries", bus8.tries, 8);
    chk("s2_result", bus8.result, 0);

    // Scenario 4: abort in the third EVAL cycle
    mode = 1;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_s = xs(m_s);
      chk("s4_cand", bus.cand, m_s[W-1:0]);
      if (i == 2) bus.abort = 1'b1;
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    chk("s4_busy", bus.busy, 0);
    chk("s4_valid", bus.cand_valid, 0);
    chk("s4_done", bus.done, 0);
    chk("s4_tries", bus.tries, 2);
    chk("s4_found", bus.found, 0);
    @(posedge clk); #1;
    chk("s4_no_late_done", bus.done, 0);
    do_search(64'd0, 1'b0, 2, 1'b0);

    // Scenario 5: zero seed substitution, then ignored pulses during EVAL
    @(posedge clk); #1; bus.seed_we = 1'b1; bus.seed_in = 64'd0;
    @(posedge clk); #1; bus.seed_we = 1'b0;
    m_s = ZSEED;
    do_search(64'd0, 1'b0, 3, 1'b1);
    do_search(64'd0, 1'b0, 2, 1'b0);

    // Scenario 6: async reset mid-EVAL, then scenario 1 again
    mode = 1;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #3; rst = 1'b1;
    #1;
    chk("s6_cand", bus.cand, 0);
    chk("s6_valid", bus.cand_valid, 0);
    chk("s6_busy", bus.busy, 0);
    chk("s6_tries", bus.tries, 0);
    chk("s6_done", bus.done, 0);
    chk("s6_found", bus.found, 0);
    chk("s6_result", bus.result, 0);
    @(posedge clk); #1; rst = 1'b0;
    m_s = ZSEED;
    do_search(64'd1, 1'b1, 0, 1'b0);
    chk("s6_repeat_result", bus.result, 55'h40822041);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
